vga_timing_gen: RTL and testbench

- Pixel-side end of the SRAM-to-VGA path.
- Generates 640x480@60 raster timing and publishes the pixel coordinate it wants next, for the frame-buffer controller to use as its SRAM address.
- Takes the returned RGB a fixed number of cycles later and drives DAC-ready RGB, sync and blank, with all of them aligned.
- Also exports vertical-blank and frame-start status so the controller can schedule its own SRAM writes outside active video.

---
 rtl/vga_timing_gen.sv | 117 +++++++++++
 tb/tb_vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing generator: publishes the next pixel coordinate to the
// frame-buffer side and realigns the returned RGB with sync/blank for the DAC.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DATA_LAT = 2,
  parameter int RGB_W    = 10
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic [3:0]       iCursor_RGB_EN,
  input  logic [RGB_W-1:0] iRed,
  input  logic [RGB_W-1:0] iGreen,
  input  logic [RGB_W-1:0] iBlue,
  output logic [9:0]       oCoord_X,
  output logic [9:0]       oCoord_Y,
  output logic             oRequest,
  output logic             oVBlank,
  output logic             oFrame_Start,
  output logic [RGB_W-1:0] oVGA_R,
  output logic [RGB_W-1:0] oVGA_G,
  output logic [RGB_W-1:0] oVGA_B,
  output logic             oVGA_H_SYNC,
  output logic             oVGA_V_SYNC,
  output logic             oVGA_BLANK,
  output logic             oVGA_SYNC
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_ACT_L   = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST    = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END    = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_ACT_L   = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END    = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       raw_act;
  logic       raw_hs;
  logic       raw_vs;

  logic [DATA_LAT-1:0] act_sr;
  logic [DATA_LAT-1:0] hs_sr;
  logic [DATA_LAT-1:0] vs_sr;

  logic unused_en;
  assign unused_en = iCursor_RGB_EN[3];

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  // oRequest is a one-way strobe with no backpressure: the pixel source must
  // present the matching RGB exactly DATA_LAT clocks after each request.
  always_comb begin
    raw_act      = ~iRST & (h_cnt < H_ACT_L) & (v_cnt < V_ACT_L);
    raw_hs       = ~iRST & (h_cnt >= HS_START) & (h_cnt < HS_END);
    raw_vs       = ~iRST & (v_cnt >= VS_START) & (v_cnt < VS_END);
    oRequest     = raw_act;
    oCoord_X     = raw_act ? h_cnt : '0;
    oCoord_Y     = raw_act ? v_cnt : '0;
    oVBlank      = ~iRST & (v_cnt >= V_ACT_L);
    oFrame_Start = ~iRST & (h_cnt == '0) & (v_cnt == '0);
  end

  // Flags ride a DATA_LAT-deep delay so they meet the returned pixel at capture.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      act_sr      <= '0;
      hs_sr       <= '0;
      vs_sr       <= '0;
      oVGA_R      <= '0;
      oVGA_G      <= '0;
      oVGA_B      <= '0;
      oVGA_H_SYNC <= 1'b1;
      oVGA_V_SYNC <= 1'b1;
      oVGA_BLANK  <= 1'b0;
    end else begin
      act_sr[0] <= raw_act;
      hs_sr[0]  <= raw_hs;
      vs_sr[0]  <= raw_vs;
      for (int i = 1; i < DATA_LAT; i++) begin
        act_sr[i] <= act_sr[i-1];
        hs_sr[i]  <= hs_sr[i-1];
        vs_sr[i]  <= vs_sr[i-1];
      end
      oVGA_R      <= (act_sr[DATA_LAT-1] & iCursor_RGB_EN[2]) ? iRed   : '0;
      oVGA_G      <= (act_sr[DATA_LAT-1] & iCursor_RGB_EN[1]) ? iGreen : '0;
      oVGA_B      <= (act_sr[DATA_LAT-1] & iCursor_RGB_EN[0]) ? iBlue  : '0;
      oVGA_H_SYNC <= ~hs_sr[DATA_LAT-1];
      oVGA_V_SYNC <= ~vs_sr[DATA_LAT-1];
      oVGA_BLANK  <= act_sr[DATA_LAT-1];
    end
  end

  assign oVGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a scaled-down raster so whole frames fit in a short run;
// a model raster feeds an expected-output queue that is popped DATA_LAT+1 clocks later.
module tb_vga_timing_gen;

  localparam int HA  = 20;
  localparam int HFP = 3;
  localparam int HSW = 5;
  localparam int HBP = 4;
  localparam int VA  = 10;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int DL  = 2;
  localparam int W   = 10;
  localparam int HT  = HA + HFP + HSW + HBP;
  localparam int VT  = VA + VFP + VSW + VBP;
  localparam int F   = HT * VT;

  typedef struct {
    logic [3:0] en;
    logic       mode;
    int         frames;
    int         exp_fs;
    int         exp_req;
    int         exp_hs_low;
    int         exp_vs_low;
    int         exp_blank;
    int         exp_vb;
  } phase_t;

  // clock/reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [3:0]   en;
  logic         mode;
  logic [W-1:0] red, green, blue;
  logic [9:0]   coord_x, coord_y;
  logic         request, vblank, frame_start;
  logic [W-1:0] vga_r, vga_g, vga_b;
  logic         vga_hs, vga_vs, vga_blank, vga_sync;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .DATA_LAT(DL), .RGB_W(W)
  ) dut (
    .iCLK(clk), .iRST(rst), .iCursor_RGB_EN(en),
    .iRed(red), .iGreen(green), .iBlue(blue),
    .oCoord_X(coord_x), .oCoord_Y(coord_y), .oRequest(request),
    .oVBlank(vblank), .oFrame_Start(frame_start),
    .oVGA_R(vga_r), .oVGA_G(vga_g), .oVGA_B(vga_b),
    .oVGA_H_SYNC(vga_hs), .oVGA_V_SYNC(vga_vs),
    .oVGA_BLANK(vga_blank), .oVGA_SYNC(vga_sync)
  );

  int checks = 0;
  int errors = 0;

  // scoreboard record: {act, hs, vs, x[9:0], y[9:0]}
  logic [22:0] exp_q[$];

  int         mh, mv, cyc;
  logic       rst_q;
  logic [3:0] cap_en;
  logic       cap_mode;
  logic [9:0] last_x, last_y;
  logic [9:0] pipe_x[DL];
  logic [9:0] pipe_y[DL];
  int cnt_fs, cnt_req, cnt_hs_low, cnt_vs_low, cnt_blank, cnt_vb;
  int last_fs, hs_run, vs_run;

  task automatic chk(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // driver: one clock of stimulus, model update, and output comparison
  task automatic step(input logic rst_v, input logic [3:0] en_v, input logic mode_v);
    logic       act, hs, vs, e_act, e_hs, e_vs;
    logic [9:0] ex, ey, e_x, e_y;
    logic [W-1:0] dr, dg, db, er, eg, eb;
    @(posedge clk);
    cyc++;
    if (rst_q) begin
      mh = 0;
      mv = 0;
    end else if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
    #1;
    for (int i = DL - 1; i > 0; i--) begin
      pipe_x[i] = pipe_x[i-1];
      pipe_y[i] = pipe_y[i-1];
    end
    pipe_x[0] = last_x;
    pipe_y[0] = last_y;
    rst  = rst_v;
    en   = en_v;
    mode = mode_v;
    if (mode_v) begin
      red = '1; green = '1; blue = '1;
    end else begin
      red   = pipe_x[DL-1];
      green = pipe_y[DL-1];
      blue  = pipe_x[DL-1] ^ pipe_y[DL-1];
    end
    #1;
    act = !rst_v && mh < HA && mv < VA;
    hs  = !rst_v && mh >= HA + HFP && mh < HA + HFP + HSW;
    vs  = !rst_v && mv >= VA + VFP && mv < VA + VFP + VSW;
    ex  = act ? 10'(mh) : 10'd0;
    ey  = act ? 10'(mv) : 10'd0;
    chk("request", {request, coord_x, coord_y, vblank, frame_start},
        {act, ex, ey, (!rst_v && mv >= VA), (!rst_v && mh == 0 && mv == 0)});

    {e_act, e_hs, e_vs, e_x, e_y} = exp_q.pop_front();
    if (cap_mode) begin
      dr = '1; dg = '1; db = '1;
    end else begin
      dr = e_x; dg = e_y; db = e_x ^ e_y;
    end
    er = (e_act && cap_en[2]) ? dr : '0;
    eg = (e_act && cap_en[1]) ? dg : '0;
    eb = (e_act && cap_en[0]) ? db : '0;
    chk("dac", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, vga_sync},
        {er, eg, eb, !e_hs, !e_vs, e_act, 1'b0});

    cnt_fs     += int'(frame_start);
    cnt_req    += int'(request);
    cnt_hs_low += int'(!vga_hs);
    cnt_vs_low += int'(!vga_vs);
    cnt_blank  += int'(vga_blank);
    cnt_vb     += int'(vblank);
    if (frame_start) begin
      if (last_fs >= 0) chk("fs_period", cyc - last_fs, F);
      last_fs = cyc;
    end
    if (!vga_hs) hs_run++;
    else begin
      if (hs_run > 0) chk("hs_width", hs_run, HSW);
      hs_run = 0;
    end
    if (!vga_vs) vs_run++;
    else begin
      if (vs_run > 0) chk("vs_width", vs_run, VSW * HT);
      vs_run = 0;
    end

    if (rst_v) begin
      exp_q.delete();
      repeat (DL + 1) exp_q.push_back('0);
      last_fs = -1;
      hs_run  = 0;
      vs_run  = 0;
    end else begin
      exp_q.push_back({act, hs, vs, ex, ey});
    end
    last_x   = coord_x;
    last_y   = coord_y;
    rst_q    = rst_v;
    cap_en   = en_v;
    cap_mode = mode_v;
  endtask

  function automatic phase_t make_phase(input logic [3:0] e, input logic m, input int n);
    phase_t p;
    p.en         = e;
    p.mode       = m;
    p.frames     = n;
    p.exp_fs     = n;
    p.exp_req    = n * HA * VA;
    p.exp_hs_low = n * VT * HSW;
    p.exp_vs_low = n * VSW * HT;
    p.exp_blank  = n * HA * VA;
    p.exp_vb     = n * (VT - VA) * HT;
    return p;
  endfunction

  phase_t ph[3];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; en = '0; mode = 1'b0;
    red = '0; green = '0; blue = '0;
    rst_q = 1'b1; cap_en = '0; cap_mode = 1'b0;
    last_x = '0; last_y = '0;
    for (int i = 0; i < DL; i++) begin
      pipe_x[i] = '0;
      pipe_y[i] = '0;
    end
    mh = 0; mv = 0; cyc = 0;
    last_fs = -1; hs_run = 0; vs_run = 0;
    repeat (DL + 1) exp_q.push_back('0);

    ph[0] = make_phase(4'b0111, 1'b0, 2);
    ph[1] = make_phase(4'b0101, 1'b1, 1);
    ph[2] = make_phase(4'b1010, 1'b0, 1);

    repeat (3) step(1'b1, 4'b0111, 1'b0);
    chk("reset_out", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank, request, frame_start, vblank},
        {30'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});

    for (int p = 0; p < 3; p++) begin
      cnt_fs = 0; cnt_req = 0; cnt_hs_low = 0; cnt_vs_low = 0; cnt_blank = 0; cnt_vb = 0;
      for (int k = 0; k < ph[p].frames * F; k++) step(1'b0, ph[p].en, ph[p].mode);
      chk($sformatf("p%0d_frame_starts", p), cnt_fs,     ph[p].exp_fs);
      chk($sformatf("p%0d_requests", p),     cnt_req,    ph[p].exp_req);
      chk($sformatf("p%0d_hsync_low", p),    cnt_hs_low, ph[p].exp_hs_low);
      chk($sformatf("p%0d_vsync_low", p),    cnt_vs_low, ph[p].exp_vs_low);
      chk($sformatf("p%0d_blank_high", p),   cnt_blank,  ph[p].exp_blank);
      chk($sformatf("p%0d_vblank", p),       cnt_vb,     ph[p].exp_vb);
    end

    // mid-frame reset inside the active area, held for 3 clocks
    for (int k = 0; k < F && !(mh == 12 && mv == 6); k++) step(1'b0, 4'b0111, 1'b0);
    chk("reach_mid_frame", {mh == 12, mv == 6}, 2'b11);
    step(1'b1, 4'b0111, 1'b0);
    step(1'b1, 4'b0111, 1'b0);
    chk("mid_reset_out", {vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_blank},
        {30'd0, 1'b1, 1'b1, 1'b0});
    step(1'b1, 4'b0111, 1'b0);
    step(1'b0, 4'b0111, 1'b0);
    chk("release_first", {frame_start, request, coord_x, coord_y}, {1'b1, 1'b1, 20'd0});

    // enable changes mid-line take effect at capture
    for (int k = 0; k < F + HT; k++)
      step(1'b0, (k % 7 < 3) ? 4'b0100 : 4'b0011, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
